// File: rtl/tune_sweep_ctrl_if.sv
// rtl/tune_sweep_ctrl_if.sv - configuration/control and tuning-word output bundle for the sweep sequencer
interface tune_sweep_ctrl_if #(
  parameter int TUNE_W = 16,
  parameter int IVL_W  = 12
);
  logic              tick;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [TUNE_W-1:0] start_word;
  logic [TUNE_W-1:0] stop_word;
  logic [TUNE_W-1:0] step_word;
  logic [IVL_W-1:0]  interval;
  logic [TUNE_W-1:0] tune_out;
  logic              tune_valid;
  logic              busy;
  logic              done;

  modport master (
    output tick, start, abort, mode, start_word, stop_word, step_word, interval,
    input  tune_out, tune_valid, busy, done
  );

  modport slave (
    input  tick, start, abort, mode, start_word, stop_word, step_word, interval,
    output tune_out, tune_valid, busy, done
  );
endinterface

// File: rtl/tune_sweep_ctrl.sv
// rtl/tune_sweep_ctrl.sv - DDS voice frequency-sweep sequencer (once / loop / ping-pong)
module tune_sweep_ctrl #(
  parameter int TUNE_W = 16,
  parameter int IVL_W  = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  tune_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  state_e            state_q, state_d;
  logic [TUNE_W-1:0] tune_q, tune_d;
  logic              valid_q, valid_d;
  logic [IVL_W-1:0]  cnt_q, cnt_d;
  logic [IVL_W-1:0]  ivl_q, ivl_d;
  logic [1:0]        mode_q, mode_d;
  logic [TUNE_W-1:0] start_q, start_d;
  logic [TUNE_W-1:0] stop_q, stop_d;
  logic [TUNE_W-1:0] step_q, step_d;
  logic [TUNE_W-1:0] target_q, target_d;
  logic              dir_q, dir_d;       // 1 = stepping down
  logic              restart_q, restart_d;

  logic [IVL_W-1:0]  ivl_last;
  logic [TUNE_W:0]   sum_w, dif_w;
  logic [TUNE_W-1:0] up_next, dn_next, step_next;
  logic              degenerate;

  // One guard bit on both sides so the clamp sees overflow/borrow instead of a wrapped value
  assign ivl_last   = (ivl_q == '0) ? '0 : ivl_q - 1'b1;
  assign sum_w      = {1'b0, tune_q} + {1'b0, step_q};
  assign dif_w      = {1'b0, tune_q} - {1'b0, step_q};
  assign up_next    = (sum_w >= {1'b0, target_q}) ? target_q : sum_w[TUNE_W-1:0];
  assign dn_next    = (dif_w[TUNE_W] || (dif_w[TUNE_W-1:0] <= target_q)) ? target_q
                                                                         : dif_w[TUNE_W-1:0];
  assign step_next  = dir_q ? dn_next : up_next;
  assign degenerate = (start_q == stop_q) || (step_q == '0);

  always_comb begin
    state_d   = state_q;
    tune_d    = tune_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    ivl_d     = ivl_q;
    mode_d    = mode_q;
    start_d   = start_q;
    stop_d    = stop_q;
    step_d    = step_q;
    target_d  = target_q;
    dir_d     = dir_q;
    restart_d = restart_q;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus.tick) begin
            if (cnt_q == ivl_last) begin
              cnt_d = '0;
              if (degenerate) begin
                state_d = S_DONE;
              end else if (restart_q) begin
                tune_d    = start_q;
                valid_d   = 1'b1;
                restart_d = 1'b0;
              end else begin
                tune_d  = step_next;
                valid_d = 1'b1;
                if (step_next == target_q) begin
                  case (mode_q)
                    MODE_LOOP: restart_d = 1'b1;
                    MODE_PING: begin
                      target_d = (target_q == stop_q) ? start_q : stop_q;
                      dir_d    = ~dir_q;
                    end
                    default:   state_d = S_DONE;
                  endcase
                end
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          if (bus.start) begin
            state_d   = S_RUN;
            mode_d    = bus.mode;
            start_d   = bus.start_word;
            stop_d    = bus.stop_word;
            step_d    = bus.step_word;
            ivl_d     = bus.interval;
            target_d  = bus.stop_word;
            dir_d     = (bus.stop_word < bus.start_word);
            restart_d = 1'b0;
            cnt_d     = '0;
            tune_d    = bus.start_word;
            valid_d   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      tune_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      ivl_q     <= '0;
      mode_q    <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      step_q    <= '0;
      target_q  <= '0;
      dir_q     <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tune_q    <= tune_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      ivl_q     <= ivl_d;
      mode_q    <= mode_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      step_q    <= step_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      restart_q <= restart_d;
    end
  end

  assign bus.tune_out   = tune_q;
  assign bus.tune_valid = valid_q;
  assign bus.busy       = (state_q == S_RUN);
  assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_tune_sweep_ctrl.sv
// tb/tb_tune_sweep_ctrl.sv - scoreboard bench for tune_sweep_ctrl
module tb_tune_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tune_sweep_ctrl_if #(.TUNE_W(16), .IVL_W(12)) vif ();

  tune_sweep_ctrl #(.TUNE_W(16), .IVL_W(12)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (vif.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  int stb_cyc[$];

  bit tick_en = 1'b0;
  int tick_per = 4;
  int tick_ph = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    vif.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vif.tick = tick_en && (tick_ph == 0);
      tick_ph = (tick_ph + 1 >= tick_per) ? 0 : tick_ph + 1;
    end
  end

  // Monitor: every strobe must match the head of the expectation queue
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && vif.tune_valid) begin
        checks++;
        stb_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe got=%0h exp=none", vif.tune_out);
        end else begin
          e = exp_q.pop_front();
          if (vif.tune_out !== e) begin
            errors++;
            $display("FAIL strobe_value got=%0h exp=%0h", vif.tune_out, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic start_sweep(input logic [1:0] m, input logic [15:0] sw, input logic [15:0] ew,
                             input logic [15:0] stp, input logic [11:0] iv);
    @(posedge clk);
    #1;
    vif.mode = m; vif.start_word = sw; vif.stop_word = ew;
    vif.step_word = stp; vif.interval = iv; vif.start = 1'b1;
    @(posedge clk);
    #1;
    vif.start = 1'b0;
    // Scramble config so any late sampling shows up as wrong strobes
    vif.mode = 2'b01; vif.start_word = 16'hABCD; vif.stop_word = 16'h7777;
    vif.step_word = 16'h0001; vif.interval = 12'd0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      #1;
      if (vif.done) seen = 1'b1;
      n++;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic pulse_abort();
    @(posedge clk);
    #1;
    vif.abort = 1'b1;
    @(posedge clk);
    #1;
    vif.abort = 1'b0;
  endtask

  initial begin
    vif.start = 1'b0; vif.abort = 1'b0; vif.mode = 2'b00;
    vif.start_word = '0; vif.stop_word = '0; vif.step_word = '0; vif.interval = '0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tune", vif.tune_out, 0);
    chk("rst_valid", vif.tune_valid, 0);
    chk("rst_busy", vif.busy, 0);
    chk("rst_done", vif.done, 0);
    tick_en = 1'b1;

    // 1: once up, five strobes 8 clk apart
    tick_per = 4;
    stb_cyc.delete();
    exp_q = '{16'h0100, 16'h0110, 16'h0120, 16'h0130, 16'h0140};
    start_sweep(2'b00, 16'h0100, 16'h0140, 16'h0010, 12'd2);
    wait_done("t1_done_timeout", 300);
    chk("t1_queue", exp_q.size(), 0);
    chk("t1_busy", vif.busy, 0);
    chk("t1_tune", vif.tune_out, 16'h0140);
    chk("t1_nstrobes", stb_cyc.size(), 5);
    for (int i = 2; i < 5 && i < stb_cyc.size(); i++)
      chk("t1_gap", stb_cyc[i] - stb_cyc[i-1], 8);

    // 2: saturation at a non-multiple endpoint
    tick_per = 2;
    exp_q = '{16'h0000, 16'h0010, 16'h0020, 16'h0025};
    start_sweep(2'b00, 16'h0000, 16'h0025, 16'h0010, 12'd1);
    wait_done("t2_done_timeout", 200);
    chk("t2_queue", exp_q.size(), 0);
    chk("t2_tune", vif.tune_out, 16'h0025);

    // 3: down without underflow, mode 11 behaves as once
    exp_q = '{16'h0008, 16'h0003, 16'h0000};
    start_sweep(2'b11, 16'h0008, 16'h0000, 16'h0005, 12'd1);
    wait_done("t3_done_timeout", 200);
    chk("t3_queue", exp_q.size(), 0);
    chk("t3_tune", vif.tune_out, 16'h0000);

    // 4: ping-pong keeps running, then abort
    tick_per = 3;
    exp_q = '{16'h10, 16'h20, 16'h30, 16'h20, 16'h10, 16'h20, 16'h30};
    start_sweep(2'b10, 16'h0010, 16'h0030, 16'h0010, 12'd1);
    wait_drain("t4_drain", 200);
    chk("t4_busy", vif.busy, 1);
    chk("t4_done", vif.done, 0);
    pulse_abort();
    chk("t4_abort_busy", vif.busy, 0);
    chk("t4_abort_tune", vif.tune_out, 16'h0030);

    // loop: endpoint then restart at start_word
    exp_q = '{16'h00, 16'h10, 16'h20, 16'h00, 16'h10, 16'h20};
    start_sweep(2'b01, 16'h0000, 16'h0020, 16'h0010, 12'd1);
    wait_drain("loop_drain", 200);
    chk("loop_busy", vif.busy, 1);
    pulse_abort();
    chk("loop_abort_tune", vif.tune_out, 16'h0020);

    // 5: abort at the third strobe, then start+abort together
    tick_per = 4;
    exp_q = '{16'h0100, 16'h0110, 16'h0120};
    start_sweep(2'b00, 16'h0100, 16'h0140, 16'h0010, 12'd2);
    wait_drain("t5_drain", 200);
    pulse_abort();
    chk("t5_busy", vif.busy, 0);
    chk("t5_done", vif.done, 0);
    chk("t5_valid", vif.tune_valid, 0);
    chk("t5_tune", vif.tune_out, 16'h0120);
    @(posedge clk);
    #1;
    vif.start = 1'b1; vif.abort = 1'b1; vif.start_word = 16'h0300;
    vif.stop_word = 16'h0400; vif.step_word = 16'h0010;
    @(posedge clk);
    #1;
    vif.start = 1'b0; vif.abort = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("t5_sa_busy", vif.busy, 0);
    chk("t5_sa_tune", vif.tune_out, 16'h0120);

    // 6: zero step gives a single start strobe then DONE
    exp_q = '{16'h0100};
    start_sweep(2'b10, 16'h0100, 16'h0140, 16'h0000, 12'd2);
    wait_done("t6_step0_timeout", 200);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_step0_tune", vif.tune_out, 16'h0100);
    chk("t6_step0_done", vif.done, 1);
    chk("t6_step0_queue", exp_q.size(), 0);

    // start in RUN ignored, then asynchronous reset mid-sweep
    exp_q = '{16'h0100, 16'h0110};
    start_sweep(2'b00, 16'h0100, 16'h0140, 16'h0010, 12'd2);
    wait_drain("t6_run_drain", 200);
    exp_q.push_back(16'h0120);
    @(posedge clk);
    #1;
    vif.start = 1'b1; vif.start_word = 16'h0500;
    @(posedge clk);
    #1;
    vif.start = 1'b0;
    wait_drain("t6_ignore_drain", 200);
    chk("t6_run_busy", vif.busy, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tune", vif.tune_out, 0);
    chk("t6_rst_busy", vif.busy, 0);
    chk("t6_rst_done", vif.done, 0);
    chk("t6_rst_valid", vif.tune_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_post_busy", vif.busy, 0);
    chk("t6_post_tune", vif.tune_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
